// File: rtl/ram_responder.sv
// NoC memory endpoint: accepts read/write requests into a RAM and returns one
// response per access through a small in-order response FIFO.
module ram_responder #(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int PACKED_IN    = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
    parameter int PACKED_OUT   = WIDTH + N_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKED_IN-1:0]    i_packed_in,
    input  logic                    i_valid_in,
    output logic                    i_ready_out,
    output logic [PACKED_OUT-1:0]   o_packed_out,
    output logic [N_ADDR_WIDTH-1:0] o_dest_out,
    output logic                    o_valid_out,
    input  logic                    o_ready_in
);

    localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [WIDTH-1:0]        ACK     = WIDTH'(1) << (WIDTH - 1);
    localparam logic [N_ADDR_WIDTH-1:0] NODE_ID = N_ADDR_WIDTH'(NODE % N);

    // Request fields, LSB first: src, read_en, write_en, addr, data
    logic [N_ADDR_WIDTH-1:0] w_src;
    logic                    w_re;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [WIDTH-1:0]        w_data;

    assign w_src  = i_packed_in[N_ADDR_WIDTH-1:0];
    assign w_re   = i_packed_in[N_ADDR_WIDTH];
    assign w_we   = i_packed_in[N_ADDR_WIDTH+1];
    assign w_addr = i_packed_in[N_ADDR_WIDTH+2 +: ADDR_WIDTH];
    assign w_data = i_packed_in[N_ADDR_WIDTH+2+ADDR_WIDTH +: WIDTH];

    logic [WIDTH-1:0]        r_ram [RAM_DEPTH];

    logic                    r_s2_valid;
    logic [WIDTH-1:0]        r_s2_data;
    logic [N_ADDR_WIDTH-1:0] r_s2_dest;

    logic [WIDTH-1:0]        r_fifo_data [FIFO_DEPTH];
    logic [N_ADDR_WIDTH-1:0] r_fifo_dest [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;

    logic                    w_accept;
    logic                    w_access;
    logic                    w_push;
    logic                    w_pop;
    logic [CW-1:0]           w_occ;

    // Stage-2 occupancy is reserved up front so a push never meets a full FIFO
    assign w_occ       = r_count + CW'(r_s2_valid);
    assign i_ready_out = ~rst & (w_occ < CW'(FIFO_DEPTH));
    assign w_accept    = i_valid_in & i_ready_out;
    assign w_access    = w_accept & (w_we | w_re);

    assign o_valid_out = (r_count != '0);
    assign w_push      = r_s2_valid;
    assign w_pop       = o_valid_out & o_ready_in;

    // Stage 1: RAM access; the synchronous read sees a write from the previous edge
    always_ff @(posedge clk) begin
        if (w_accept && w_we) begin
            r_ram[w_addr] <= w_data;
        end
        if (w_access) begin
            r_s2_data <= w_we ? ACK : r_ram[w_addr];
            r_s2_dest <= w_src;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_s2_data;
            r_fifo_dest[r_wr_ptr] <= r_s2_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_s2_valid <= w_access;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_packed_out = '0;
        o_dest_out   = '0;
        if (o_valid_out) begin
            o_packed_out = {r_fifo_data[r_rd_ptr], NODE_ID};
            o_dest_out   = r_fifo_dest[r_rd_ptr];
        end
    end

endmodule
